// File: rtl/rx_ber_meter.sv
// rx_ber_meter: bit-error-rate meter for a PRBS link.
// Finds the link latency by testing each candidate delay for one window. It
// then counts compared bits and errors while locked. It drops lock and
// resumes the search when a window's error count reaches LOS_TH.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-low reset
//   i_enable    sample strobe; one rx/ref bit pair per strobed cycle
//   i_rx_bit    detected bit from the receiver
//   i_ref_bit   local PRBS reference bit
//   i_clear     zeroes the bit/error counters (lock state untouched)
//   o_lock      1 while locked
//   o_latency   candidate latency (search) or locked latency
//   o_bit_count saturating count of bits compared while locked
//   o_err_count saturating count of errors while locked
//
// state    | meaning
// S_SEARCH | testing candidate latency o_latency for one window
// S_LOCK   | latency found, counting bits and errors
module rx_ber_meter #(
    parameter int MAX_LAT = 63,
    parameter int LAT_W   = 6,
    parameter int WIN_LEN = 128,
    parameter int LOCK_TH = 0,
    parameter int LOS_TH  = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic             i_rx_bit,
    input  logic             i_ref_bit,
    input  logic             i_clear,
    output logic             o_lock,
    output logic [LAT_W-1:0] o_latency,
    output logic [CNT_W-1:0] o_bit_count,
    output logic [CNT_W-1:0] o_err_count
);

    localparam int WC_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int WE_W = $clog2(WIN_LEN + 1);
    localparam int WE_X = WE_W + 1;
    localparam logic [WC_W-1:0]  WIN_LAST  = WC_W'(WIN_LEN - 1);
    localparam logic [WE_W-1:0]  WIN_SAT   = WE_W'(WIN_LEN);
    localparam logic [WE_X-1:0]  LOCK_TH_C = WE_X'(LOCK_TH);
    localparam logic [WE_X-1:0]  LOS_TH_C  = WE_X'(LOS_TH);
    localparam logic [LAT_W-1:0] LAT_MAX   = LAT_W'(MAX_LAT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic {S_SEARCH, S_LOCK} state_t;

    state_t             state_q, state_d;
    logic               lock_q, lock_d;
    logic [LAT_W-1:0]   lat_q, lat_d, lat_next;
    logic [MAX_LAT-1:0] hist_q, hist_d;
    logic [WC_W-1:0]    win_cnt_q, win_cnt_d;
    logic [WE_W-1:0]    win_err_q, win_err_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

    // Entry 0 is the live reference bit; entry k is the bit k samples back.
    logic [MAX_LAT:0]   ref_vec;
    logic               err;
    logic               win_close;
    logic [WE_X-1:0]    e_tot;

    assign ref_vec   = {hist_q, i_ref_bit};
    assign err       = i_rx_bit ^ ref_vec[lat_q];
    assign win_close = i_enable && (win_cnt_q == WIN_LAST);
    // Window total including the sample being consumed now.
    assign e_tot     = {1'b0, win_err_q} + WE_X'(err);
    assign lat_next  = (lat_q == LAT_MAX) ? '0 : lat_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        lock_d    = lock_q;
        lat_d     = lat_q;
        hist_d    = hist_q;
        win_cnt_d = win_cnt_q;
        win_err_d = win_err_q;
        bit_cnt_d = bit_cnt_q;
        err_cnt_d = err_cnt_q;

        if (i_enable) begin
            hist_d    = ref_vec[MAX_LAT-1:0];
            win_cnt_d = win_close ? '0 : win_cnt_q + 1'b1;
            if (win_close) begin
                win_err_d = '0;
            end else if (err && (win_err_q != WIN_SAT)) begin
                win_err_d = win_err_q + 1'b1;
            end

            case (state_q)
                S_SEARCH: begin
                    if (win_close) begin
                        if (e_tot <= LOCK_TH_C) begin
                            state_d = S_LOCK;
                            lock_d  = 1'b1;
                        end else begin
                            lat_d = lat_next;
                        end
                    end
                end
                S_LOCK: begin
                    if (bit_cnt_q != CNT_MAX) bit_cnt_d = bit_cnt_q + 1'b1;
                    if (err && (err_cnt_q != CNT_MAX)) err_cnt_d = err_cnt_q + 1'b1;
                    if (win_close && (e_tot >= LOS_TH_C)) begin
                        state_d = S_SEARCH;
                        lock_d  = 1'b0;
                        lat_d   = lat_next;
                    end
                end
                default: state_d = S_SEARCH;
            endcase
        end

        // Clear overrides any same-cycle count.
        if (i_clear) begin
            bit_cnt_d = '0;
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_SEARCH;
            lock_q    <= 1'b0;
            lat_q     <= '0;
            hist_q    <= '0;
            win_cnt_q <= '0;
            win_err_q <= '0;
            bit_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_q    <= lock_d;
            lat_q     <= lat_d;
            hist_q    <= hist_d;
            win_cnt_q <= win_cnt_d;
            win_err_q <= win_err_d;
            bit_cnt_q <= bit_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_lock      = lock_q;
    assign o_latency   = lat_q;
    assign o_bit_count = bit_cnt_q;
    assign o_err_count = err_cnt_q;

endmodule

// File: tb/tb_rx_ber_meter.sv
module tb_rx_ber_meter;

    logic        clk;
    logic        rst;
    logic        en;
    logic        ref_i;
    logic        rx;
    logic        clear;
    logic        s_rx;
    logic        s_clear;

    logic        lock;
    logic [5:0]  lat;
    logic [31:0] bits;
    logic [31:0] errs;
    logic        s_lock;
    logic [5:0]  s_lat;
    logic [3:0]  s_bits;
    logic [3:0]  s_errs;

    int          n_cmp = 0;
    int          n_bad = 0;

    // Channel model: PRBS9 source and a delay line of past reference bits.
    logic [8:0]  lfsr = 9'h1FF;
    logic [63:0] th   = '0;
    int          dly  = 0;

    rx_ber_meter u_dut (
        .clk         (clk),
        .rst         (rst),
        .i_enable    (en),
        .i_rx_bit    (rx),
        .i_ref_bit   (ref_i),
        .i_clear     (clear),
        .o_lock      (lock),
        .o_latency   (lat),
        .o_bit_count (bits),
        .o_err_count (errs)
    );

    rx_ber_meter #(.CNT_W(4), .LOS_TH(129)) u_sat (
        .clk         (clk),
        .rst         (rst),
        .i_enable    (en),
        .i_rx_bit    (s_rx),
        .i_ref_bit   (ref_i),
        .i_clear     (s_clear),
        .o_lock      (s_lock),
        .o_latency   (s_lat),
        .o_bit_count (s_bits),
        .o_err_count (s_errs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic chan(input int d, input logic r);
        return (d == 0) ? r : th[d-1];
    endfunction

    // One cycle: present inputs, clock them in, sample #1 after the edge.
    task automatic smp(input logic e, input logic inj, input logic sinv);
        logic r;
        r     = lfsr[8];
        en    = e;
        ref_i = r;
        rx    = chan(dly, r) ^ inj;
        s_rx  = chan(dly, r) ^ sinv;
        @(posedge clk);
        #1;
        if (e) begin
            th   = {th[62:0], r};
            lfsr = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
        end
    endtask

    initial begin
        int add;
        rst = 1'b0; en = 1'b0; ref_i = 1'b0; rx = 1'b0;
        clear = 1'b0; s_rx = 1'b0; s_clear = 1'b0;

        // Reset state
        smp(0, 0, 0);
        smp(0, 0, 0);
        chk("rst_lock", lock, 0);
        chk("rst_lat", lat, 0);
        chk("rst_bits", bits, 0);
        chk("rst_errs", errs, 0);
        rst = 1'b1;

        // Clean acquisition at delay 5: lock after 6 windows
        dly = 5;
        repeat (767) smp(1, 0, 0);
        chk("acq_pre_lock", lock, 0);
        chk("acq_pre_lat", lat, 5);
        smp(1, 0, 0);
        chk("acq_lock", lock, 1);
        chk("acq_lat", lat, 5);
        chk("acq_bits", bits, 0);
        repeat (1000) smp(1, 0, 0);
        chk("cnt_bits", bits, 1000);
        chk("cnt_errs", errs, 0);

        // Clear without strobe, then 1-in-100 error injection
        clear = 1'b1;
        smp(0, 0, 0);
        clear = 1'b0;
        chk("clr_bits", bits, 0);
        chk("clr_errs", errs, 0);
        chk("clr_lock", lock, 1);
        for (int j = 0; j < 10000; j++) smp(1, (j % 100) == 99, 0);
        chk("inj_bits", bits, 10000);
        chk("inj_errs", errs, 100);
        chk("inj_lock", lock, 1);

        // Align to a window boundary, then move the channel to delay 9
        repeat (8) smp(1, 0, 0);
        dly = 9;
        add = 0;
        for (int i = 0; i < 127; i++) begin
            add += int'(chan(9, lfsr[8]) != chan(5, lfsr[8]));
            smp(1, 0, 0);
        end
        chk("los_pre_lock", lock, 1);
        add += int'(chan(9, lfsr[8]) != chan(5, lfsr[8]));
        smp(1, 0, 0);
        chk("los_lock", lock, 0);
        chk("los_lat", lat, 6);
        chk("los_bits", bits, 10136);
        chk("los_errs", errs, 32'(100 + add));
        repeat (511) smp(1, 0, 0);
        chk("relock_pre", lock, 0);
        smp(1, 0, 0);
        chk("relock_lock", lock, 1);
        chk("relock_lat", lat, 9);
        chk("relock_bits", bits, 10136);
        chk("relock_errs", errs, 32'(100 + add));

        // Reset mid-lock, reacquire at 9
        rst = 1'b0;
        smp(0, 0, 0);
        rst = 1'b1;
        chk("mrst_lock", lock, 0);
        chk("mrst_lat", lat, 0);
        chk("mrst_bits", bits, 0);
        chk("mrst_errs", errs, 0);
        repeat (1279) smp(1, 0, 0);
        chk("reacq_pre", lock, 0);
        smp(1, 0, 0);
        chk("reacq_lock", lock, 1);
        chk("reacq_lat", lat, 9);
        chk("sat_lock", s_lock, 1);
        chk("sat_lat", s_lat, 9);

        // Saturation on the 4-bit instance, rx inverted on odd samples
        for (int j = 0; j < 30; j++) begin
            smp(1, 0, j[0]);
            if (j == 14) begin
                chk("sat_bits15", s_bits, 15);
                chk("sat_errs7", s_errs, 7);
            end
        end
        chk("sat_bits_hold", s_bits, 15);
        chk("sat_errs15", s_errs, 15);
        repeat (4) smp(1, 0, 1);
        chk("sat_errs_hold", s_errs, 15);
        clear   = 1'b1;
        s_clear = 1'b1;
        smp(1, 0, 1);
        clear   = 1'b0;
        s_clear = 1'b0;
        chk("sclr_bits", s_bits, 0);
        chk("sclr_errs", s_errs, 0);
        chk("sclr_lock", s_lock, 1);
        chk("mclr_bits", bits, 0);
        smp(1, 0, 1);
        chk("sat_after_bits", s_bits, 1);
        chk("sat_after_errs", s_errs, 1);

        // Strobe gating: 1 in 4 cycles, delay 3
        rst = 1'b0;
        smp(0, 0, 0);
        rst = 1'b1;
        dly = 3;
        repeat (511) begin
            smp(1, 0, 0);
            repeat (3) smp(0, 0, 0);
        end
        chk("stb_pre", lock, 0);
        smp(1, 0, 0);
        chk("stb_lock", lock, 1);
        chk("stb_lat", lat, 3);
        repeat (3) smp(0, 0, 0);
        smp(1, 0, 0);
        chk("stb_bits1", bits, 1);
        repeat (3) smp(0, 0, 0);
        chk("stb_bits1_hold", bits, 1);
        repeat (9) begin
            smp(1, 0, 0);
            repeat (3) smp(0, 0, 0);
        end
        chk("stb_bits10", bits, 10);
        chk("stb_errs", errs, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rx_ber_meter.md
# rx_ber_meter

Parametrised bit-error-rate meter for the PRBS link. It sits after the receiver's detector and compares the detected bit stream against the local PRBS reference. It automatically finds the link latency in symbols, then counts compared bits and bit errors. It declares loss of lock when the error rate in a window exceeds a threshold, then searches again.

## Interface

Parameters:

- MAX_LAT, default 63: largest latency searched, in enabled samples. The reference history depth is MAX_LAT+1.
- LAT_W, default 6: width of the latency index; must satisfy 2^LAT_W > MAX_LAT.
- WIN_LEN, default 128: samples per evaluation window, used in both SEARCH and LOCK; must be ≥ 2.
- LOCK_TH, default 0: maximum errors in a SEARCH window to declare lock.
- LOS_TH, default 16: error count in a LOCK window at or above which lock is lost.
- CNT_W, default 32: width of the bit and error counters.

Ports:

- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-low reset.
- i_enable, input, 1: sample strobe; one bit pair is consumed per cycle with i_enable=1.
- i_rx_bit, input, 1: detected bit from the receiver.
- i_ref_bit, input, 1: reference bit from the PRBS generator, driven with the same i_enable.
- i_clear, input, 1: synchronous clear of o_bit_count and o_err_count; lock state is unaffected.
- o_lock, output, 1: 1 while in LOCK.
- o_latency, output, LAT_W: current candidate latency in SEARCH, or the locked latency in LOCK.
- o_bit_count, output, CNT_W: number of bits compared while locked; saturating.
- o_err_count, output, CNT_W: number of errors while locked; saturating.

## Operation

- **Reference history.** ref_hist[0..MAX_LAT] is a shift register advanced only when i_enable=1.
  - ref_hist[0] is the current i_ref_bit.
  - ref_hist[k] is the reference bit from k enabled samples earlier.
  - Reset clears the history to 0.
- **Compare.** On every enabled cycle, err = i_rx_bit XOR ref_hist[o_latency].
- **win_cnt.** Counts enabled samples from 0 to WIN_LEN-1, then wraps to 0. The sample at win_cnt = WIN_LEN-1 closes the window.
- **win_err.** Counts errors within the window. It saturates at WIN_LEN and is cleared when the window closes.
- **State SEARCH** (entered at reset):
  - At window close, let e be the window error total, including the closing sample's error.
  - If e ≤ LOCK_TH: go to LOCK, keep o_latency, set o_lock=1.
  - Otherwise: o_latency increments, wrapping MAX_LAT→0, and the next window starts on the next enabled sample.
- **State LOCK:**
  - Every enabled sample increments o_bit_count, and increments o_err_count when err=1.
  - At window close, if e ≥ LOS_TH: go to SEARCH, o_lock=0, o_latency increments with wrap. The search resumes from the next candidate.
  - The bit and error counters hold their values in SEARCH and are not cleared by loss of lock.
- **Counter saturation.** Each counter stops at 2^CNT_W-1 and holds; the other counter continues counting.
- **i_clear.**
  - Zeroes both counters on the next edge.
  - If i_clear coincides with an enabled LOCK sample, the counters become 0, not 1; clear wins.
  - i_clear has no effect on the state, o_latency, or the window counters.
- **i_enable=0.** All registers hold, except that i_clear still acts.

## Timing

- All outputs are registered.
- **Reset values:** o_lock=0, o_latency=0, o_bit_count=0, o_err_count=0, state SEARCH, win_cnt=0, win_err=0.
- **Reset mid-operation:** the same values apply on the next edge; the history is cleared.
- **Lock latency:** the sample closing the successful window produces o_lock=1 on the following clock edge. That closing sample is not counted in o_bit_count.
- **Counting:** the first counted sample is the next enabled sample after o_lock rises. Each counted sample updates the counters one edge after its cycle.
- **Loss of lock:** the closing sample of the failing window is still counted; o_lock falls on the same edge that counts it.
- **Worst-case acquisition** with a clean link at latency L: (L+1)·WIN_LEN enabled samples when searching from reset. After reset, the first MAX_LAT samples compare against zeroed history; windows that fail because of this simply advance the search.

## Test plan

- **Clean acquisition.** Drive PRBS9 with i_enable=1 every cycle and i_rx_bit = i_ref_bit delayed 5 samples.
  - o_lock rises after 6·128 samples, plus 1 edge, with o_latency=5.
  - After 1000 further samples: o_bit_count=1000, o_err_count=0.
- **Error injection.** While locked, invert 1 of every 100 rx bits over 10000 samples.
  - o_err_count=100, o_bit_count=10000, o_lock stays 1 (1–2 errors per window < 16).
- **Loss of lock and relock.** While locked at 5, change the channel delay to 9.
  - o_lock falls at the end of the current window.
  - The search resumes at 6, 7, … and relocks with o_latency=9.
  - The counters keep their pre-loss values plus the errors of the failing window.
- **Strobe gating.** Use i_enable at 1 of every 4 cycles with a delay of 3 samples.
  - Lock is declared at latency 3 after 4·128 enabled samples.
  - All counters advance only on strobe cycles.
- **Saturation and clear.** With CNT_W=4, rx inverted 1 in 2 and LOS_TH=WIN_LEN+1 so lock holds:
  - o_bit_count sticks at 15 while o_err_count continues to 15.
  - Asserting i_clear gives 0/0 on the next edge; o_lock stays 1.
- **Reset mid-lock.** Pulse rst=0 for 1 cycle.
  - All outputs are 0 on the next edge.
  - Reacquisition completes with the same latency as before.
